// File: rtl/ram32x3_arbiter.sv
// Two-port round-robin front end for a 32x3 single-port RAM.
// After each reset it zero-fills the RAM, then arbitrates pipelined reads and writes.
module ram32x3_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [4:0] addr0,
    input  logic [4:0] addr1,
    input  logic [2:0] wdata0,
    input  logic [2:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [2:0] rdata0,
    output logic [2:0] rdata1,
    output logic       busy,
    output logic [4:0] mem_addr,
    output logic [2:0] mem_data,
    output logic       mem_wren,
    input  logic [2:0] mem_q
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t      state;
    logic [5:0]  clr_cnt;
    logic        fav1;

    // Read tags: stage 0 lines up with mem_addr, stage RD_LAT with mem_q.
    logic [RD_LAT:0] pipe_vld;
    logic [RD_LAT:0] pipe_port;

    assign busy = (state == CLEAR);
    assign gnt0 = (state == RUN) && req0 && (!req1 || !fav1);
    assign gnt1 = (state == RUN) && req1 && (!req0 || fav1);

    // NOTE: every register here uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            fav1     <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    // Bit 5 set means address 31 went out on the previous edge.
                    if (clr_cnt[5]) begin
                        state    <= RUN;
                        mem_wren <= 1'b0;
                    end else begin
                        mem_wren <= 1'b1;
                        mem_addr <= clr_cnt[4:0];
                        mem_data <= '0;
                        clr_cnt  <= clr_cnt + 6'd1;
                    end
                end
                RUN: begin
                    mem_wren <= 1'b0;
                    if (gnt0) begin
                        mem_addr <= addr0;
                        mem_data <= wdata0;
                        mem_wren <= we0;
                        fav1     <= 1'b1;
                    end else if (gnt1) begin
                        mem_addr <= addr1;
                        mem_data <= wdata1;
                        mem_wren <= we1;
                        fav1     <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the tag pipeline is reset, unlike a data RAM, so a reset kills in-flight reads.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            pipe_vld[0]  <= (gnt0 && !we0) || (gnt1 && !we1);
            pipe_port[0] <= gnt1;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
            rvalid0 <= pipe_vld[RD_LAT] && !pipe_port[RD_LAT];
            rvalid1 <= pipe_vld[RD_LAT] &&  pipe_port[RD_LAT];
            if (pipe_vld[RD_LAT] && !pipe_port[RD_LAT])
                rdata0 <= mem_q;
            if (pipe_vld[RD_LAT] && pipe_port[RD_LAT])
                rdata1 <= mem_q;
        end
    end

endmodule

// File: tb/tb_ram32x3_arbiter.sv
// Bench for ram32x3_arbiter: behavioural RAM, shadow-memory reference model and
// a scoreboard monitor that checks grants, the RAM bus and tagged read returns.
module tb_ram32x3_arbiter;

    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [2:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_wren;
    logic [2:0] rdata0, rdata1, mem_data;
    logic [4:0] mem_addr;
    logic [2:0] mem_q = '0;

    logic [2:0] ram [32] = '{default: 3'b101};

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ram32x3_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .Reset_n(Reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    // RAM with one cycle of read latency, matching RD_LAT = 1.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        mem_q <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow contents, round-robin pointer, expected returns.
    typedef struct {
        logic [2:0] data;
        int         due;
    } rd_t;

    rd_t        q0[$], q1[$];
    rd_t        e_rd;
    logic [2:0] shadow [32];
    bit         sb_en = 1'b0;
    bit         fav1_m, pg, pwe, eg0, eg1;
    logic [4:0] paddr_e;
    logic [2:0] pdata_e;
    int         cyc;

    task automatic model_init();
        for (int i = 0; i < 32; i++) shadow[i] = 3'b000;
        fav1_m  = 1'b0;
        pg      = 1'b0;
        pwe     = 1'b0;
        paddr_e = 5'd31;
        pdata_e = 3'b000;
        cyc     = 32;
        q0.delete();
        q1.delete();
    endtask

    always @(negedge clk) begin
        if (sb_en) begin
            if (rvalid0) begin
                if (q0.size() == 0) check("rvalid0_unexpected", rvalid0, 1'b0);
                else begin
                    e_rd = q0.pop_front();
                    check("rdata0", rdata0, e_rd.data);
                    check("rvalid0_cycle", cyc, e_rd.due);
                end
            end
            if (rvalid1) begin
                if (q1.size() == 0) check("rvalid1_unexpected", rvalid1, 1'b0);
                else begin
                    e_rd = q1.pop_front();
                    check("rdata1", rdata1, e_rd.data);
                    check("rvalid1_cycle", cyc, e_rd.due);
                end
            end
            check("mem_wren", mem_wren, pg & pwe);
            check("mem_addr", mem_addr, paddr_e);
            check("mem_data", mem_data, pdata_e);

            eg0 = req0 && (!req1 || !fav1_m);
            eg1 = req1 && !eg0;
            check("gnt", {gnt1, gnt0}, {eg1, eg0});
            pg = eg0 || eg1;
            if (eg0) begin
                pwe = we0; paddr_e = addr0; pdata_e = wdata0; fav1_m = 1'b1;
                if (we0) shadow[addr0] = wdata0;
                else q0.push_back('{data: shadow[addr0], due: cyc + 2 + RD_LAT});
            end else if (eg1) begin
                pwe = we1; paddr_e = addr1; pdata_e = wdata1; fav1_m = 1'b0;
                if (we1) shadow[addr1] = wdata1;
                else q1.push_back('{data: shadow[addr1], due: cyc + 2 + RD_LAT});
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_gnt", {gnt1, gnt0}, 2'b00);
        check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        check("rst_rdata", {rdata1, rdata0}, 6'd0);
        check("rst_mem_wren", mem_wren, 1'b0);
        check("rst_mem_addr", mem_addr, 5'd0);
        check("rst_mem_data", mem_data, 3'd0);
        check("rst_busy", busy, 1'b1);
    endtask

    // Called just after reset release; ends at the falling edge of cycle 32.
    task automatic do_clear(input bit with_req);
        for (int k = 0; k <= 32; k++) begin
            step();
            if (with_req && k == 3) begin
                req1 = 1'b1; we1 = 1'b0; addr1 = 5'd31; wdata1 = 3'b011;
            end
            if (k == 32) begin
                model_init();
                sb_en = 1'b1;
            end
            @(negedge clk);
            if (k < 32) begin
                check("clear_wren", mem_wren, 1'b1);
                check("clear_addr", mem_addr, k);
                check("clear_data", mem_data, 3'b000);
                check("clear_busy", busy, 1'b1);
                check("clear_gnt", {gnt1, gnt0}, 2'b00);
                check("clear_rvalid", {rvalid1, rvalid0}, 2'b00);
            end else begin
                check("run_busy", busy, 1'b0);
                check("run_wren", mem_wren, 1'b0);
                if (with_req) check("gnt1_first_run", gnt1, 1'b1);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the grant with the request dropped.
    task automatic drive(input bit p, input bit we, input logic [4:0] a, input logic [2:0] d);
        int n = 0;
        if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        @(negedge clk);
        while (!(p ? gnt1 : gnt0) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n == 50) check(p ? "gnt1_timeout" : "gnt0_timeout", p ? gnt1 : gnt0, 1'b1);
        step();
        if (p) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got0 = 1'b0, got1 = 1'b0;

        req0 = 1'b1; we0 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        req0 = 1'b0; we0 = 1'b0;
        Reset_n = 1'b1;

        do_clear(1'b1);
        step();
        req1 = 1'b0;
        repeat (3) step();

        drive(1'b0, 1'b1, 5'd5, 3'b110);
        drive(1'b0, 1'b0, 5'd5, 3'b000);
        repeat (5) step();
        drive(1'b1, 1'b0, 5'd31, 3'b000);
        repeat (4) step();

        // Last grant went to port 1, so contention starts with port 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("contention_gnt", {gnt1, gnt0}, (i % 2) ? 2'b10 : 2'b01);
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();

        for (int c = 0; c < 400; c++) begin
            if (!req0 || got0) begin
                req0 = ($urandom_range(0, 99) < 70); we0 = $urandom_range(0, 1);
                addr0 = $urandom_range(0, 7); wdata0 = $urandom_range(0, 7);
            end
            if (!req1 || got1) begin
                req1 = ($urandom_range(0, 99) < 70); we1 = $urandom_range(0, 1);
                addr1 = $urandom_range(0, 7); wdata1 = $urandom_range(0, 7);
            end
            @(negedge clk);
            got0 = gnt0;
            got1 = gnt1;
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        // Reset one cycle after a read grant; its return would land in clear cycle 1.
        drive(1'b0, 1'b0, 5'd5, 3'b000);
        Reset_n = 1'b0;
        sb_en = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        Reset_n = 1'b1;
        do_clear(1'b0);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ram32x3_arbiter.md
RAM32X3_ARBITER -- requirements
Module: ram32x3_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from mem_addr presented to mem_q valid.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have port Reset_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req0 / req1, input, 1 each: access request, port 0 / port 1.
REQ-005 SHALL have port we0 / we1, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have port addr0 / addr1, input, 5 each: word address.
REQ-007 SHALL have port wdata0 / wdata1, input, 3 each: write data.
REQ-008 SHALL have port gnt0 / gnt1, output, 1 each: request accepted this cycle; combinational.
REQ-009 SHALL have port rvalid0 / rvalid1, output, 1 each: one-cycle read-return strobe.
REQ-010 SHALL have port rdata0 / rdata1, output, 3 each: read data, valid with the matching rvalid.
REQ-011 SHALL have port busy, output, 1: clear sequence in progress.
REQ-012 SHALL have port mem_addr, output, 5, registered: RAM address.
REQ-013 SHALL have port mem_data, output, 3, registered: RAM write data.
REQ-014 SHALL have port mem_wren, output, 1, registered: RAM write enable.
REQ-015 SHALL have port mem_q, input, 3: RAM read data.

Function
REQ-016 SHALL implement two states, CLEAR and RUN; reset enters CLEAR.
REQ-017 CLEAR SHALL behave as follows.
- Write 0 to addresses 0..31 in ascending order, one per cycle.
- In cycle k after the first edge following reset release (k=0..31): mem_wren=1, mem_addr=k, mem_data=0.
- busy=1 throughout; gnt0 = gnt1 = 0.
REQ-018 After address 31 is written, the block SHALL enter RUN. busy=0 and mem_wren=0 from cycle 32 onward.
REQ-019 In RUN, at most one gnt SHALL assert per cycle. gnt_i=1 only when req_i=1.
REQ-020 With a single requester, that port SHALL be granted every cycle it requests.
REQ-021 With both requesting, grant SHALL go to the port not granted most recently (round-robin). After reset, port 0 is favoured.
REQ-022 A request granted in cycle N SHALL drive mem_addr / mem_data / mem_wren (wren = we_i) in cycle N+1.
REQ-023 In cycles with no grant, mem_wren SHALL be 0 and mem_addr / mem_data SHALL hold their last values.
REQ-024 A read granted to port i in cycle N SHALL return as follows.
- mem_q is sampled in cycle N+1+RD_LAT.
- rdata_i is registered; rvalid_i=1 for exactly cycle N+2+RD_LAT.
REQ-025 Reads SHALL be fully pipelined: one access per cycle sustained. Returns stay in grant order and are tagged to the originating port.
REQ-026 A write to address A granted in cycle N, followed by a read of A granted in cycle N+1, SHALL return the new data.
REQ-027 Requesters SHALL hold req / we / addr / wdata stable until granted. The block SHALL never drop or duplicate an accepted request.
REQ-028 Requests presented during CLEAR SHALL be held off (no gnt) and serviced once RUN begins.
REQ-029 Writes SHALL produce no rvalid.

Reset
REQ-030 Reset_n=0 SHALL immediately force the following values.
- gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
- mem_wren=0, mem_addr=0, mem_data=0, busy=1.
- State = CLEAR, round-robin favours port 0.
REQ-031 On reset mid-operation, in-flight reads SHALL be discarded with no rvalid, and the clear sequence SHALL restart from address 0 after release.

Verification
REQ-032 Clear sequence: release reset, no requests -> mem_wren=1 with mem_addr 0..31 over 32 cycles, mem_data=0, busy falls at cycle 32.
REQ-033 Single-port write / read: port 0 writes addr 5, data 3'b110, then reads addr 5 in the next cycle -> rdata0=3'b110 with rvalid0 at grant+3 (RD_LAT=1); rvalid1 stays 0.
REQ-034 Contention: req0 and req1 held together for 4 cycles -> grants alternate 0,1,0,1, one per cycle, never both.
REQ-035 Cleared contents: after clear, port 1 reads addr 31 -> rdata1=3'b000.
REQ-036 Request during CLEAR: req1 asserted at cycle 3 of the clear -> gnt1 first asserts in cycle 32.
REQ-037 Reset mid-read: Reset_n pulsed low while a read is outstanding -> no rvalid for that read, outputs at reset values, clear restarts at address 0.
